// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file geometry constants
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; search starts one past ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int   idx;
  logic hit;

  // walk the ring from farthest to nearest so the nearest valid requester is the last one written
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt_idx = IDW'(idx);
        hit     = 1'b1;
      end
    end
    if (en && hit) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares one register-file read port between NREQ requesters
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     rf_sel,
  input  logic [DW-1:0]     rf_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_data,
  input  logic              rsp_ready
);

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  s1_id;
  logic            s1_valid;
  logic            stall;
  logic            adv1;
  logic            accept_en;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   s2_data;

  assign stall     = rsp_valid & ~rsp_ready;
  assign adv1      = ~stall;
  assign accept_en = ~reset & (~s1_valid | adv1);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (accept_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];

  // rf_data still shows the old value on the edge a write commits, so forward the write
  always_comb begin
    s2_data = rf_data;
    if (rf_sel == AW'(REG_ZERO)) s2_data = '0;
    else if (wr_en && (wr_addr == rf_sel)) s2_data = wr_data;
  end

  // rf_sel doubles as the S1 address
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      rf_sel    <= '0;
      ptr       <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (|gnt) begin
        s1_valid <= 1'b1;
        s1_id    <= gnt_idx;
        rf_sel   <= sel_addr;
        ptr      <= gnt_idx;
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end
      if (s1_valid && adv1) begin
        rsp_valid <= 1'b1;
        rsp_id    <= s1_id;
        rsp_data  <= s2_data;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - directed and random checks of regfile_read_arbiter against a transaction model
module tb_regfile_read_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     rf_sel;
  logic [DW-1:0]     rf_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready;

  always #5 clk = ~clk;

  // the register file behind the external read mux
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rf_data = mem[rf_sel];

  regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    int id;
    int addr;
    int t;
  } item_t;

  item_t         pending[$];
  int            grant_log[$];
  int            rsp_log[$];
  int            ptr_m;
  int            cyc;
  int            total;
  int            bad;
  int            last_w;
  int            last_id;
  int            last_lat;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: predict grant, step the edge, then reconcile responses with the model
  task automatic cycle();
    logic [NREQ-1:0]    exp_rdy;
    logic [NREQ*AW-1:0] addr_pre;
    logic [IDW-1:0]     id_pre;
    logic [DW-1:0]      d_pre;
    logic [AW-1:0]      sel_pre;
    logic [DW-1:0]      exp_d;
    logic               rv_pre, rr_pre, rst_pre;
    bit                 stall, allowed;
    int                 w, npend_pre;
    item_t              it;
    #1;
    stall   = rsp_valid && !rsp_ready;
    allowed = !reset && (!stall || pending.size() == 0);
    exp_rdy = '0;
    w       = -1;
    if (allowed) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && req_valid[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    addr_pre  = req_addr;
    id_pre    = rsp_id;
    d_pre     = rsp_data;
    sel_pre   = rf_sel;
    rv_pre    = rsp_valid;
    rr_pre    = rsp_ready;
    rst_pre   = reset;
    npend_pre = pending.size();
    last_w    = w;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_pre) begin
      pending.delete();
      ptr_m = NREQ - 1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_id", 64'(rsp_id), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      chk("reset_rf_sel", 64'(rf_sel), 64'(0));
      return;
    end
    if (w >= 0) begin
      pending.push_back('{id: w, addr: int'(addr_pre[w*AW +: AW]), t: cyc - 1});
      ptr_m = w;
      grant_log.push_back(w);
      chk("rf_sel_load", 64'(rf_sel), 64'(addr_pre[w*AW +: AW]));
    end else if (stall && npend_pre > 0) begin
      chk("rf_sel_hold", 64'(rf_sel), 64'(sel_pre));
    end
    if (rv_pre && !rr_pre) begin
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_id", 64'(rsp_id), 64'(id_pre));
      chk("hold_data", 64'(rsp_data), 64'(d_pre));
    end else if (rsp_valid) begin
      chk("rsp_expected", 64'(pending.size() > 0), 64'(1));
      if (pending.size() > 0) begin
        it    = pending.pop_front();
        exp_d = (it.addr == 0) ? '0 : mem[it.addr];
        chk("rsp_id", 64'(rsp_id), 64'(it.id));
        chk("rsp_data", 64'(rsp_data), 64'(exp_d));
        last_id   = int'(rsp_id);
        last_data = rsp_data;
        last_lat  = cyc - it.t;
        rsp_log.push_back(int'(rsp_id));
      end
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input int a0, input int a1, input logic rdy);
    req_valid        = v;
    req_addr[0 +: AW]  = AW'(a0);
    req_addr[AW +: AW] = AW'(a1);
    rsp_ready        = rdy;
  endtask

  initial begin
    int gl_before;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    ptr_m     = NREQ - 1;
    last_w    = -1;
    last_id   = -1;
    last_lat  = 0;
    last_data = '0;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    // load the register file while held in reset
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = (i == 5) ? 32'h1234 : (i == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle();
    end
    wr_en = 1'b0;
    reset = 1'b0;

    // 1: single read, latency two
    drive(3'b001, 5, 0, 1'b1);
    cycle();
    drive(3'b000, 0, 0, 1'b1);
    cycle();
    cycle();
    chk("t1_id", 64'(last_id), 64'(0));
    chk("t1_data", 64'(last_data), 64'h1234);
    chk("t1_latency", 64'(last_lat), 64'(2));

    // 3: address zero reads as zero regardless of the mux
    drive(3'b010, 0, 0, 1'b1);
    cycle();
    drive(3'b000, 0, 0, 1'b1);
    cycle();
    cycle();
    chk("t3_id", 64'(last_id), 64'(1));
    chk("t3_data", 64'(last_data), 64'(0));

    // 2: alternating grants
    grant_log.delete();
    rsp_log.delete();
    drive(3'b011, 1, 2, 1'b1);
    repeat (4) cycle();
    drive(3'b000, 0, 0, 1'b1);
    repeat (3) cycle();
    chk("t2_grants", 64'(grant_log.size()), 64'(4));
    chk("t2_rsps", 64'(rsp_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < grant_log.size() && i < rsp_log.size(); i++) begin
      chk("t2_grant_order", 64'(grant_log[i]), 64'(i % 2));
      chk("t2_rsp_order", 64'(rsp_log[i]), 64'(i % 2));
    end

    // 4: write-through bypass on the advancing edge
    drive(3'b001, 7, 0, 1'b1);
    cycle();
    drive(3'b000, 0, 0, 1'b1);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hCAFE;
    cycle();
    wr_en = 1'b0;
    cycle();
    chk("t4_id", 64'(last_id), 64'(0));
    chk("t4_data", 64'(last_data), 64'hCAFE);

    // 5: three stalled cycles with both requesters pending
    grant_log.delete();
    rsp_log.delete();
    drive(3'b011, 3, 4, 1'b1);
    repeat (2) cycle();
    gl_before = grant_log.size();
    rsp_ready = 1'b0;
    repeat (3) cycle();
    chk("t5_no_grant", 64'(grant_log.size()), 64'(gl_before));
    rsp_ready = 1'b1;
    repeat (2) cycle();
    drive(3'b000, 0, 0, 1'b1);
    repeat (4) cycle();
    chk("t5_drain", 64'(pending.size()), 64'(0));
    chk("t5_count", 64'(rsp_log.size()), 64'(grant_log.size()));

    // 6: reset with both stages full
    drive(3'b011, 9, 10, 1'b0);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    chk("t6_first_winner", 64'(last_w), 64'(0));
    drive(3'b000, 0, 0, 1'b1);
    repeat (4) cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((req_valid[i] && last_w == i) || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      wr_en     = ($urandom_range(0, 9) < 4);
      wr_addr   = ($urandom_range(0, 1) == 1) ? rf_sel : AW'($urandom_range(0, 31));
      wr_data   = $urandom;
      reset     = ($urandom_range(0, 149) == 0);
      cycle();
    end

    reset     = 1'b0;
    wr_en     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) cycle();
    chk("final_drain", 64'(pending.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
